// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor_if
// Brief    : Pixel, sprite-ROM and RGB signal bundle for sprite_compositor.
// Revision : 1.0  initial release
// ============================================================================
interface sprite_compositor_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank_n;
    logic        hs_in;
    logic        vs_in;
    logic [1:0]  game_state;
    logic [9:0]  bird_x;
    logic [9:0]  bird_y;
    logic [10:0] bird_addr;
    logic [13:0] title_addr;
    logic [12:0] names_addr;
    logic [12:0] go_addr;
    logic [23:0] bird_data;
    logic [23:0] title_data;
    logic [23:0] names_data;
    logic [23:0] go_data;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        hs_out;
    logic        vs_out;
    logic        blank_n_out;

    modport master (
        output DrawX, DrawY, blank_n, hs_in, vs_in, game_state, bird_x, bird_y,
               bird_data, title_data, names_data, go_data,
        input  bird_addr, title_addr, names_addr, go_addr,
               Red, Green, Blue, hs_out, vs_out, blank_n_out
    );

    modport slave (
        input  DrawX, DrawY, blank_n, hs_in, vs_in, game_state, bird_x, bird_y,
               bird_data, title_data, names_data, go_data,
        output bird_addr, title_addr, names_addr, go_addr,
               Red, Green, Blue, hs_out, vs_out, blank_n_out
    );
endinterface
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Brief    : 3-stage sprite hit/address, ROM capture and layer-select pipeline.
// Revision : 1.0  initial release
// ============================================================================
module sprite_compositor #(
    parameter int          BIRD_W    = 44,
    parameter int          BIRD_H    = 32,
    parameter int          TITLE_W   = 200,
    parameter int          TITLE_H   = 53,
    parameter int          TITLE_X   = 220,
    parameter int          TITLE_Y   = 80,
    parameter int          NAMES_W   = 160,
    parameter int          NAMES_H   = 30,
    parameter int          NAMES_X   = 240,
    parameter int          NAMES_Y   = 300,
    parameter int          GO_W      = 103,
    parameter int          GO_H      = 55,
    parameter int          GO_X      = 268,
    parameter int          GO_Y      = 150,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
    parameter logic [23:0] BG_COLOR  = 24'h4EC0CA,
    parameter int          BLINK_BIT = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    sprite_compositor_if.slave bus
);
    localparam logic [1:0] c_ST_TITLE    = 2'd0;
    localparam logic [1:0] c_ST_GAMEOVER = 2'd2;
    localparam int         c_L_BIRD      = 0;
    localparam int         c_L_TITLE     = 1;
    localparam int         c_L_NAMES     = 2;
    localparam int         c_L_GO        = 3;

    // 11-bit compare so org+len beyond 1023 stays beyond the screen
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org, input int len);
        return ({1'b0, pos} >= {1'b0, org}) && ({1'b0, pos} < ({1'b0, org} + 11'(len)));
    endfunction

    logic [9:0]  w_bird_dx, w_bird_dy, w_title_dx, w_title_dy;
    logic [9:0]  w_names_dx, w_names_dy, w_go_dx, w_go_dy;
    logic [10:0] w_bird_addr;
    logic [13:0] w_title_addr;
    logic [12:0] w_names_addr, w_go_addr;
    logic [3:0]  w_hit;
    logic [23:0] w_pix;

    logic        r_vs_d;
    logic [5:0]  r_frame;
    logic [3:0]  r1_hit, r2_hit;
    logic [1:0]  r1_state, r2_state;
    logic        r1_blank, r2_blank, r3_blank;
    logic        r1_hs, r2_hs, r3_hs;
    logic        r1_vs, r2_vs, r3_vs;
    logic        r1_blink, r2_blink;
    logic [10:0] r1_bird_addr;
    logic [13:0] r1_title_addr;
    logic [12:0] r1_names_addr, r1_go_addr;
    logic [23:0] r2_bird_data, r2_title_data, r2_names_data, r2_go_data;
    logic [23:0] r3_rgb;

    always_comb begin
        w_bird_dx  = bus.DrawX - bus.bird_x;
        w_bird_dy  = bus.DrawY - bus.bird_y;
        w_title_dx = bus.DrawX - 10'(TITLE_X);
        w_title_dy = bus.DrawY - 10'(TITLE_Y);
        w_names_dx = bus.DrawX - 10'(NAMES_X);
        w_names_dy = bus.DrawY - 10'(NAMES_Y);
        w_go_dx    = bus.DrawX - 10'(GO_X);
        w_go_dy    = bus.DrawY - 10'(GO_Y);

        w_bird_addr  = 11'(32'(w_bird_dy)  * 32'(BIRD_W)  + 32'(w_bird_dx));
        w_title_addr = 14'(32'(w_title_dy) * 32'(TITLE_W) + 32'(w_title_dx));
        w_names_addr = 13'(32'(w_names_dy) * 32'(NAMES_W) + 32'(w_names_dx));
        w_go_addr    = 13'(32'(w_go_dy)    * 32'(GO_W)    + 32'(w_go_dx));

        w_hit[c_L_BIRD]  = in_span(bus.DrawX, bus.bird_x, BIRD_W)
                        && in_span(bus.DrawY, bus.bird_y, BIRD_H);
        w_hit[c_L_TITLE] = in_span(bus.DrawX, 10'(TITLE_X), TITLE_W)
                        && in_span(bus.DrawY, 10'(TITLE_Y), TITLE_H);
        w_hit[c_L_NAMES] = in_span(bus.DrawX, 10'(NAMES_X), NAMES_W)
                        && in_span(bus.DrawY, 10'(NAMES_Y), NAMES_H);
        w_hit[c_L_GO]    = in_span(bus.DrawX, 10'(GO_X), GO_W)
                        && in_span(bus.DrawY, 10'(GO_Y), GO_H);
    end

    // Highest-priority contributing layer wins; blanking overrides everything
    always_comb begin
        w_pix = BG_COLOR;
        if (r2_state == c_ST_GAMEOVER && r2_hit[c_L_GO] && r2_go_data != KEY_COLOR)
            w_pix = r2_go_data;
        else if (r2_state == c_ST_TITLE && r2_blink && r2_hit[c_L_NAMES] && r2_names_data != KEY_COLOR)
            w_pix = r2_names_data;
        else if (r2_state == c_ST_TITLE && r2_hit[c_L_TITLE] && r2_title_data != KEY_COLOR)
            w_pix = r2_title_data;
        else if (r2_hit[c_L_BIRD] && r2_bird_data != KEY_COLOR)
            w_pix = r2_bird_data;
        if (!r2_blank)
            w_pix = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vs_d        <= 1'b0;
            r_frame       <= '0;
            r1_hit        <= '0;
            r2_hit        <= '0;
            r1_state      <= '0;
            r2_state      <= '0;
            r1_blank      <= 1'b0;
            r2_blank      <= 1'b0;
            r3_blank      <= 1'b0;
            r1_hs         <= 1'b0;
            r2_hs         <= 1'b0;
            r3_hs         <= 1'b0;
            r1_vs         <= 1'b0;
            r2_vs         <= 1'b0;
            r3_vs         <= 1'b0;
            r1_blink      <= 1'b0;
            r2_blink      <= 1'b0;
            r1_bird_addr  <= '0;
            r1_title_addr <= '0;
            r1_names_addr <= '0;
            r1_go_addr    <= '0;
            r2_bird_data  <= '0;
            r2_title_data <= '0;
            r2_names_data <= '0;
            r2_go_data    <= '0;
            r3_rgb        <= '0;
        end else begin
            r_vs_d <= bus.vs_in;
            if (r_vs_d && !bus.vs_in)
                r_frame <= r_frame + 6'd1;

            r1_hit        <= w_hit;
            r1_bird_addr  <= w_hit[c_L_BIRD]  ? w_bird_addr  : '0;
            r1_title_addr <= w_hit[c_L_TITLE] ? w_title_addr : '0;
            r1_names_addr <= w_hit[c_L_NAMES] ? w_names_addr : '0;
            r1_go_addr    <= w_hit[c_L_GO]    ? w_go_addr    : '0;
            r1_state      <= bus.game_state;
            r1_blank      <= bus.blank_n;
            r1_hs         <= bus.hs_in;
            r1_vs         <= bus.vs_in;
            r1_blink      <= ~r_frame[BLINK_BIT];

            r2_hit        <= r1_hit;
            r2_state      <= r1_state;
            r2_blank      <= r1_blank;
            r2_hs         <= r1_hs;
            r2_vs         <= r1_vs;
            r2_blink      <= r1_blink;
            r2_bird_data  <= bus.bird_data;
            r2_title_data <= bus.title_data;
            r2_names_data <= bus.names_data;
            r2_go_data    <= bus.go_data;

            r3_rgb   <= w_pix;
            r3_hs    <= r2_hs;
            r3_vs    <= r2_vs;
            r3_blank <= r2_blank;
        end
    end

    assign bus.bird_addr   = r1_bird_addr;
    assign bus.title_addr  = r1_title_addr;
    assign bus.names_addr  = r1_names_addr;
    assign bus.go_addr     = r1_go_addr;
    assign bus.Red         = r3_rgb[23:16];
    assign bus.Green       = r3_rgb[15:8];
    assign bus.Blue        = r3_rgb[7:0];
    assign bus.hs_out      = r3_hs;
    assign bus.vs_out      = r3_vs;
    assign bus.blank_n_out = r3_blank;
endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Brief    : Randomized + directed bench for sprite_compositor with a pixel model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_compositor;
    localparam logic [23:0] c_KEY = 24'hFF00FF;
    localparam logic [23:0] c_BG  = 24'h4EC0CA;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [10:0] ba;
        logic [13:0] ta;
        logic [12:0] na;
        logic [12:0] ga;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_compositor_if bus ();
    sprite_compositor dut (.Clk(clk), .Reset(rst), .bus(bus));

    logic [23:0] bird_rom  [0:2047];
    logic [23:0] title_rom [0:16383];
    logic [23:0] names_rom [0:8191];
    logic [23:0] go_rom    [0:8191];

    int   total = 0;
    int   bad   = 0;
    bit   model_ok = 0;
    bit   done = 0;
    exp_t p0, p1, p2;
    int   frame;
    bit   prev_vs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, want);
        end
    endtask

    function automatic bit inside_box(int x, int y, int ox, int oy, int w, int h);
        return x >= ox && x < ox + w && y >= oy && y < oy + h;
    endfunction

    // Reference pixel: every layer as a rectangle, then painter's order from lowest priority
    function automatic exp_t pixel_model(int x, int y, int bx, int by, int st, bit blank,
                                         bit hs, bit vs, bit gate);
        exp_t e;
        bit bh, th, nh, gh;
        bh = inside_box(x, y, bx, by, 44, 32);
        th = inside_box(x, y, 220, 80, 200, 53);
        nh = inside_box(x, y, 240, 300, 160, 30);
        gh = inside_box(x, y, 268, 150, 103, 55);
        e.ba = bh ? 11'((y - by) * 44 + (x - bx)) : 11'd0;
        e.ta = th ? 14'((y - 80) * 200 + (x - 220)) : 14'd0;
        e.na = nh ? 13'((y - 300) * 160 + (x - 240)) : 13'd0;
        e.ga = gh ? 13'((y - 150) * 103 + (x - 268)) : 13'd0;
        e.rgb = c_BG;
        if (bh && bird_rom[e.ba] != c_KEY) e.rgb = bird_rom[e.ba];
        if (st == 0 && th && title_rom[e.ta] != c_KEY) e.rgb = title_rom[e.ta];
        if (st == 0 && gate && nh && names_rom[e.na] != c_KEY) e.rgb = names_rom[e.na];
        if (st == 2 && gh && go_rom[e.ga] != c_KEY) e.rgb = go_rom[e.ga];
        if (!blank) e.rgb = 24'h0;
        e.hs = hs;
        e.vs = vs;
        e.bl = blank;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            p0 = '0; p1 = '0; p2 = '0;
            frame = 0;
            prev_vs = 0;
            model_ok = 1;
        end else begin
            p2 = p1;
            p1 = p0;
            p0 = pixel_model(int'(bus.DrawX), int'(bus.DrawY), int'(bus.bird_x), int'(bus.bird_y),
                             int'(bus.game_state), bus.blank_n, bus.hs_in, bus.vs_in,
                             ((frame >> 5) & 1) == 0);
            if (prev_vs && !bus.vs_in) frame = (frame + 1) % 64;
            prev_vs = bus.vs_in;
        end
    end

    // Sprite ROMs: data for the address the DUT presented at the previous edge
    always @(posedge clk) begin
        #1;
        bus.bird_data  = bird_rom[bus.bird_addr];
        bus.title_data = title_rom[bus.title_addr];
        bus.names_data = names_rom[bus.names_addr];
        bus.go_data    = go_rom[bus.go_addr];
    end

    always @(negedge clk) begin
        if (model_ok && !done) begin
            chk("m_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'(p2.rgb));
            chk("m_sync", 32'({bus.hs_out, bus.vs_out, bus.blank_n_out}), 32'({p2.hs, p2.vs, p2.bl}));
            chk("m_bird_addr", 32'(bus.bird_addr), 32'(p0.ba));
            chk("m_rom_addrs", 32'({bus.title_addr, bus.names_addr, bus.go_addr}),
                32'({p0.ta, p0.na, p0.ga}));
        end
    end

    function automatic logic [31:0] rgb_now();
        return 32'({bus.Red, bus.Green, bus.Blue});
    endfunction

    task automatic px(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_falls(input int n);
        for (int i = 0; i < n; i++) begin
            bus.vs_in = 1'b1;
            @(negedge clk);
            bus.vs_in = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)  bird_rom[i]  = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
        for (int i = 0; i < 16384; i++) title_rom[i] = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
        for (int i = 0; i < 8192; i++)  names_rom[i] = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
        for (int i = 0; i < 8192; i++)  go_rom[i]    = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
        bird_rom[1407] = 24'h123456;
        bird_rom[1406] = c_KEY;
        bird_rom[450]  = 24'h000000;
        bird_rom[451]  = 24'h000000;
        go_rom[2092]   = 24'hFFFFFF;
        go_rom[2093]   = c_KEY;
        names_rom[0]   = 24'hAA0000;

        bus.bird_data = '0; bus.title_data = '0; bus.names_data = '0; bus.go_data = '0;
        bus.blank_n = 1'b1; bus.hs_in = 1'b0; bus.vs_in = 1'b0; bus.game_state = 2'd1;
        bus.bird_x = 10'd900; bus.bird_y = 10'd900;
        px(0, 0);
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        chk("rst_rgb_c0", rgb_now(), 32'h0);
        chk("rst_sync_c0", 32'({bus.hs_out, bus.vs_out, bus.blank_n_out}), 32'h0);
        hold(1); chk("rst_rgb_c1", rgb_now(), 32'h0);
        hold(1); chk("rst_rgb_c2", rgb_now(), 32'h0);
        hold(1); chk("rst_rgb_bg", rgb_now(), 32'h4EC0CA);

        bus.bird_x = 10'd100; bus.bird_y = 10'd200;
        px(143, 231);
        hold(1); chk("bird_addr_1407", 32'(bus.bird_addr), 32'd1407);
        hold(2); chk("bird_rgb", rgb_now(), 32'h123456);
        px(144, 231);
        hold(1); chk("bird_edge_addr", 32'(bus.bird_addr), 32'd0);
        hold(2); chk("bird_edge_bg", rgb_now(), 32'h4EC0CA);
        px(142, 231);
        hold(3); chk("bird_key_bg", rgb_now(), 32'h4EC0CA);

        bus.bird_x = 10'd1010; bus.bird_y = 10'd0;
        px(5, 5);
        hold(1); chk("nowrap_addr", 32'(bus.bird_addr), 32'd0);
        hold(2); chk("nowrap_bg", rgb_now(), 32'h4EC0CA);

        bus.game_state = 2'd2;
        bus.bird_x = 10'd290; bus.bird_y = 10'd160;
        px(300, 170);
        hold(3); chk("go_over_bird", rgb_now(), 32'hFFFFFF);
        px(301, 170);
        hold(3); chk("go_key_bird", rgb_now(), 32'h000000);

        bus.game_state = 2'd0;
        bus.bird_x = 10'd900; bus.bird_y = 10'd900;
        px(240, 300);
        hold(3); chk("blink_on", rgb_now(), 32'hAA0000);
        vs_falls(32);
        hold(3); chk("blink_off", rgb_now(), 32'h4EC0CA);
        vs_falls(32);
        hold(3); chk("blink_wrap", rgb_now(), 32'hAA0000);

        bus.game_state = 2'd1;
        bus.bird_x = 10'd100; bus.bird_y = 10'd200;
        px(143, 231);
        bus.blank_n = 1'b0;
        hold(3); chk("blank_rgb", rgb_now(), 32'h0);
        chk("blank_out", 32'(bus.blank_n_out), 32'h0);
        bus.blank_n = 1'b1;
        hold(3);
        bus.hs_in = 1'b1;
        hold(1); chk("hs_d1", 32'(bus.hs_out), 32'h0);
        bus.hs_in = 1'b0;
        hold(1); chk("hs_d2", 32'(bus.hs_out), 32'h0);
        hold(1); chk("hs_d3", 32'(bus.hs_out), 32'h1);
        hold(1); chk("hs_d4", 32'(bus.hs_out), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            int k;
            if (i % 40 == 0) begin
                bus.bird_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023))
                                                         : 10'($urandom_range(0, 1023));
                bus.bird_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023))
                                                         : 10'($urandom_range(0, 479));
            end
            if (i % 97 == 0) bus.game_state = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 4);
            case (k)
                0: px(int'(bus.bird_x) + $urandom_range(0, 50) - 3, int'(bus.bird_y) + $urandom_range(0, 38) - 3);
                1: px(215 + $urandom_range(0, 210), 75 + $urandom_range(0, 63));
                2: px(235 + $urandom_range(0, 170), 295 + $urandom_range(0, 40));
                3: px(263 + $urandom_range(0, 113), 145 + $urandom_range(0, 65));
                default: px($urandom_range(0, 1023), $urandom_range(0, 1023));
            endcase
            bus.blank_n = ($urandom_range(0, 9) != 0);
            bus.hs_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.vs_in = ~bus.vs_in;
            rst = (i == 1500 || i == 1501);
            @(negedge clk);
        end
        rst = 1'b0;
        hold(4);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
